n64rgb_demux: RTL and testbench

// Parametrised successor to the N64 VI bus demultiplexer. Splits the multiplexed

---
 rtl/n64rgb_pkg.sv | 12 +
 rtl/n64rgb_mode_det.sv | 50 +++++
 rtl/n64rgb_demux.sv | 98 +++++++++
 tb/tb_n64rgb_demux.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/n64rgb_pkg.sv
// Shared constants for the N64 VI demultiplexer: deblur mode codes and sync-word bit positions.
// No logic, no latency, no flow control.
package n64rgb_pkg;
    localparam logic [1:0] DEBLUR_AUTO = 2'd0;
    localparam logic [1:0] DEBLUR_ON   = 2'd1;
    localparam logic [1:0] DEBLUR_OFF  = 2'd2;

    localparam int SYNC_V  = 3;
    localparam int SYNC_CL = 2;
    localparam int SYNC_H  = 1;
    localparam int SYNC_C  = 0;
endpackage

// File: rtl/n64rgb_mode_det.sv
// Sync register and 240p/480i detection from vsync serration, plus field parity.
// Edge flags are combinational against the registered sync word; no backpressure.
module n64rgb_mode_det
    import n64rgb_pkg::*;
#(
    parameter int SERR_W      = 3,
    parameter int SERR_THRESH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync_cyc,
    input  logic [3:0] sync_in,
    output logic [3:0] syncs,
    output logic       hsync_rise,
    output logic       csync_rise,
    output logic       is_480i,
    output logic       field
);
    localparam logic [SERR_W-1:0] SERR_MAX = '1;
    localparam logic [SERR_W:0]   THRESH   = SERR_THRESH[SERR_W:0];

    logic [SERR_W-1:0] serr;
    logic              vsync_fall;
    logic              vsync_rise;

    assign vsync_fall = syncs[SYNC_V] & ~sync_in[SYNC_V];
    assign vsync_rise = ~syncs[SYNC_V] & sync_in[SYNC_V];
    assign csync_rise = ~syncs[SYNC_C] & sync_in[SYNC_C];
    assign hsync_rise = ~syncs[SYNC_H] & sync_in[SYNC_H];

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            syncs   <= 4'hF;
            serr    <= '0;
            is_480i <= 1'b0;
            field   <= 1'b0;
        end else if (sync_cyc) begin
            syncs <= sync_in;
            // The vsync-start clear wins over a serration that lands on the same word.
            if (vsync_fall) begin
                serr  <= '0;
                field <= is_480i ? ~field : 1'b0;
            end else if (csync_rise && !syncs[SYNC_V] && serr != SERR_MAX) begin
                serr <= serr + 1'b1;
            end
            if (vsync_rise)
                is_480i <= ({1'b0, serr} >= THRESH);
        end
    end
endmodule

// File: rtl/n64rgb_demux.sv
// Splits the multiplexed N64 VI sync/R/G/B word stream into parallel colour and sync outputs.
// RGB and PIX_VALID update on the same falling edge that samples B; no backpressure.
module n64rgb_demux
    import n64rgb_pkg::*;
#(
    parameter int COLOR_W     = 7,
    parameter int SERR_W      = 3,
    parameter int SERR_THRESH = 4,
    parameter int PIX_W       = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               nDSYNC,
    input  logic [COLOR_W-1:0] DI,
    input  logic [1:0]         DEBLUR_MODE,
    output logic [COLOR_W-1:0] R_o,
    output logic [COLOR_W-1:0] G_o,
    output logic [COLOR_W-1:0] B_o,
    output logic               nVSYNC,
    output logic               nCLAMP,
    output logic               nHSYNC,
    output logic               nCSYNC,
    output logic               PIX_VALID,
    output logic [PIX_W-1:0]   PIX_X,
    output logic               IS_480I,
    output logic               FIELD
);
    logic [3:0]         syncs;
    logic               hsync_rise;
    logic               csync_rise;
    logic [1:0]         cnt;
    logic               skip;
    logic [1:0]         mode_q;
    logic [COLOR_W-1:0] r_stg;
    logic [COLOR_W-1:0] g_stg;
    logic               en;

    n64rgb_mode_det #(
        .SERR_W      (SERR_W),
        .SERR_THRESH (SERR_THRESH)
    ) u_mode_det (
        .clk        (CLK),
        .rst        (RST),
        .sync_cyc   (~nDSYNC),
        .sync_in    (DI[3:0]),
        .syncs      (syncs),
        .hsync_rise (hsync_rise),
        .csync_rise (csync_rise),
        .is_480i    (IS_480I),
        .field      (FIELD)
    );

    assign {nVSYNC, nCLAMP, nHSYNC, nCSYNC} = syncs;

    // Force-off commits everything; force-on ignores interlace and relies on skip alone.
    assign en = (mode_q == DEBLUR_OFF) | skip | ((mode_q != DEBLUR_ON) & IS_480I);

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            R_o       <= '0;
            G_o       <= '0;
            B_o       <= '0;
            r_stg     <= '0;
            g_stg     <= '0;
            PIX_VALID <= 1'b0;
            PIX_X     <= '0;
            cnt       <= 2'd0;
            skip      <= 1'b0;
            mode_q    <= DEBLUR_AUTO;
        end else begin
            PIX_VALID <= 1'b0;
            if (!nDSYNC) begin
                cnt    <= 2'd0;
                mode_q <= DEBLUR_MODE;
                skip   <= csync_rise ? 1'b0 : ~skip;
                if (hsync_rise)
                    PIX_X <= '0;
            end else begin
                if (cnt != 2'd3)
                    cnt <= cnt + 2'd1;
                case (cnt)
                    2'd0: r_stg <= DI;
                    2'd1: g_stg <= DI;
                    2'd2: begin
                        if (en) begin
                            R_o       <= r_stg;
                            G_o       <= g_stg;
                            B_o       <= DI;
                            PIX_VALID <= 1'b1;
                            PIX_X     <= PIX_X + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_n64rgb_demux.sv
// Scoreboarded bench for n64rgb_demux: directed VI word streams, expected pixels queued at stimulus time.
module tb_n64rgb_demux;
    localparam logic [6:0] S_IDLE = 7'h0F;
    localparam logic [6:0] S_HS   = 7'h0C;
    localparam logic [6:0] S_V    = 7'h07;
    localparam logic [6:0] S_VC   = 7'h06;

    typedef struct packed {
        logic [6:0] r;
        logic [6:0] g;
        logic [6:0] b;
        logic [9:0] x;
    } px_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       nDSYNC = 1'b0;
    logic [6:0] DI = S_IDLE;
    logic [1:0] DEBLUR_MODE = 2'd0;
    logic [6:0] R_o, G_o, B_o;
    logic       nVSYNC, nCLAMP, nHSYNC, nCSYNC;
    logic       PIX_VALID;
    logic [9:0] PIX_X;
    logic       IS_480I, FIELD;

    px_t        q[$];
    px_t        last;
    logic [9:0] exp_x = '0;
    int         n_cmp = 0;
    int         n_bad = 0;

    n64rgb_demux dut (
        .CLK         (CLK),
        .RST         (RST),
        .nDSYNC      (nDSYNC),
        .DI          (DI),
        .DEBLUR_MODE (DEBLUR_MODE),
        .R_o         (R_o),
        .G_o         (G_o),
        .B_o         (B_o),
        .nVSYNC      (nVSYNC),
        .nCLAMP      (nCLAMP),
        .nHSYNC      (nHSYNC),
        .nCSYNC      (nCSYNC),
        .PIX_VALID   (PIX_VALID),
        .PIX_X       (PIX_X),
        .IS_480I     (IS_480I),
        .FIELD       (FIELD)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Monitor: DUT updates on the falling edge, so the rising edge sees stable outputs.
    always @(posedge CLK) begin
        if (PIX_VALID) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pixel: got rgb=%h/%h/%h x=%0d required no PIX_VALID",
                         R_o, G_o, B_o, PIX_X);
            end else begin
                px_t e;
                e = q.pop_front();
                if ({R_o, G_o, B_o, PIX_X} !== e) begin
                    n_bad++;
                    $display("FAIL pixel: got rgb=%h/%h/%h x=%0d required rgb=%h/%h/%h x=%0d",
                             R_o, G_o, B_o, PIX_X, e.r, e.g, e.b, e.x);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic word(input logic nd, input logic [6:0] d);
        @(posedge CLK);
        nDSYNC = nd;
        DI     = d;
    endtask

    task automatic data3(input logic [6:0] r, input logic [6:0] g, input logic [6:0] b,
                         input logic commit);
        px_t e;
        word(1'b1, r);
        word(1'b1, g);
        word(1'b1, b);
        if (commit) begin
            exp_x = exp_x + 10'd1;
            e = '{r: r, g: g, b: b, x: exp_x};
            q.push_back(e);
            last = e;
        end
    endtask

    task automatic pix(input logic [6:0] r, input logic [6:0] g, input logic [6:0] b,
                       input logic commit);
        word(1'b0, S_IDLE);
        data3(r, g, b, commit);
    endtask

    task automatic line_start();
        exp_x = '0;
        word(1'b0, S_HS);
    endtask

    task automatic vsync_block(input int n);
        word(1'b0, S_V);
        repeat (n) begin
            word(1'b0, S_VC);
            word(1'b0, S_V);
        end
        word(1'b0, S_IDLE);
        @(negedge CLK);
        #1;
    endtask

    initial begin
        #1 RST = 1'b1;
        #2;
        chk("reset_rgb", {R_o, G_o, B_o}, 21'h0);
        chk("reset_syncs", {nVSYNC, nCLAMP, nHSYNC, nCSYNC}, 4'hF);
        chk("reset_pix", {PIX_VALID, PIX_X}, 11'h0);
        chk("reset_mode", {IS_480I, FIELD}, 2'b00);
        repeat (2) @(posedge CLK);
        RST = 1'b0;

        // 240p auto: 3 serrations, only alternate pixels commit
        vsync_block(3);
        chk("240p_is480i", IS_480I, 1'b0);
        chk("240p_field", FIELD, 1'b0);
        line_start();
        pix(7'h11, 7'h22, 7'h33, 1'b0);
        pix(7'h44, 7'h55, 7'h66, 1'b1);
        pix(7'h01, 7'h02, 7'h03, 1'b0);
        pix(7'h04, 7'h05, 7'h06, 1'b1);
        @(negedge CLK);
        #1;
        chk("240p_pix_x", PIX_X, 10'd2);

        // deblur forced off in 240p: every pixel commits
        DEBLUR_MODE = 2'd2;
        line_start();
        pix(7'h21, 7'h22, 7'h23, 1'b1);
        pix(7'h24, 7'h25, 7'h26, 1'b1);
        pix(7'h27, 7'h28, 7'h29, 1'b1);

        // truncated pixel: sync after two data words
        word(1'b0, S_IDLE);
        word(1'b1, 7'h0A);
        word(1'b1, 7'h0B);
        word(1'b0, S_IDLE);
        @(negedge CLK);
        #1;
        chk("trunc_r", R_o, 7'h27);
        chk("trunc_g", G_o, 7'h28);
        chk("trunc_b", B_o, 7'h29);
        data3(7'h31, 7'h32, 7'h33, 1'b1);
        word(1'b1, 7'h7F);
        word(1'b1, 7'h7E);

        // PIX_X wrap over 1025 commits without hsync
        line_start();
        for (int i = 0; i < 1025; i++) begin
            logic [31:0] v;
            v = i;
            pix(v[6:0], v[6:0] ^ 7'h55, ~v[6:0], 1'b1);
        end
        @(negedge CLK);
        #1;
        chk("wrap_pix_x", PIX_X, 10'd1);
        word(1'b0, S_HS);
        word(1'b0, S_IDLE);
        @(negedge CLK);
        #1;
        chk("hsync_clears_x", PIX_X, 10'd0);
        exp_x = '0;
        data3(7'h41, 7'h42, 7'h43, 1'b1);

        // 480i auto: 6 serrations, every pixel commits, field toggles
        DEBLUR_MODE = 2'd0;
        vsync_block(6);
        chk("480i_is480i", IS_480I, 1'b1);
        chk("480i_field0", FIELD, 1'b0);
        line_start();
        pix(7'h51, 7'h52, 7'h53, 1'b1);
        pix(7'h54, 7'h55, 7'h56, 1'b1);
        pix(7'h57, 7'h58, 7'h59, 1'b1);
        vsync_block(6);
        chk("480i_field1", FIELD, 1'b1);
        chk("480i_hold", IS_480I, 1'b1);

        // deblur forced on in 480i: alternate pixels only
        DEBLUR_MODE = 2'd1;
        line_start();
        pix(7'h61, 7'h62, 7'h63, 1'b0);
        pix(7'h64, 7'h65, 7'h66, 1'b1);
        pix(7'h67, 7'h68, 7'h69, 1'b0);
        pix(7'h6A, 7'h6B, 7'h6C, 1'b1);

        // reset mid-pixel
        word(1'b0, S_IDLE);
        word(1'b1, 7'h5A);
        word(1'b1, 7'h5B);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("rst_rgb", {R_o, G_o, B_o}, 21'h0);
        chk("rst_syncs", {nVSYNC, nCLAMP, nHSYNC, nCSYNC}, 4'hF);
        chk("rst_pix", {PIX_VALID, PIX_X}, 11'h0);
        chk("rst_mode", {IS_480I, FIELD}, 2'b00);
        nDSYNC = 1'b0;
        DI = S_IDLE;
        DEBLUR_MODE = 2'd0;
        repeat (2) @(posedge CLK);
        RST = 1'b0;

        // serration saturation and threshold boundaries
        vsync_block(9);
        chk("sat_is480i", IS_480I, 1'b1);
        chk("sat_field", FIELD, 1'b0);
        vsync_block(4);
        chk("thresh4_is480i", IS_480I, 1'b1);
        chk("thresh4_field", FIELD, 1'b1);
        vsync_block(3);
        chk("thresh3_is480i", IS_480I, 1'b0);
        chk("thresh3_field", FIELD, 1'b0);

        repeat (4) @(posedge CLK);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
